cmsdk_mcu_ahb_slave_mux: RTL and testbench

//  Data-phase AHB response multiplexer with built-in default slave and error logger.

---
 rtl/cmsdk_mcu_ahb_slave_mux_if.sv | 43 ++++
 rtl/cmsdk_mcu_ahb_slave_mux.sv | 171 +++++++++++++++++
 tb/tb_cmsdk_mcu_ahb_slave_mux.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmsdk_mcu_ahb_slave_mux_if.sv
// ----------------------------------------------------------------------------
// cmsdk_mcu_ahb_slave_mux_if
//   Bus bundle between the CPU/decoder/slave side of the MCU interconnect and
//   the data-phase response multiplexer.
//
//   Address-phase request : haddr, htrans, hwrite, hsel_vec, defslv_hsel
//   Per-slave responses   : hreadyout_s, hresp_s, hrdata_s (slave i at
//                           hrdata_s[32*i+31:32*i])
//   Muxed bus response    : hready, hresp, hrdata
//
//   Modports:
//     slave  - the multiplexer's view (consumes requests and slave responses,
//              drives the muxed response)
//     master - the surrounding fabric's view (drives requests and slave
//              responses, consumes the muxed response)
// ----------------------------------------------------------------------------
interface cmsdk_mcu_ahb_slave_mux_if #(
    parameter int NUM_SLV = 8
);
    logic [31:0]          haddr;
    logic [1:0]           htrans;
    logic                 hwrite;
    logic [NUM_SLV-1:0]   hsel_vec;
    logic                 defslv_hsel;
    logic [NUM_SLV-1:0]   hreadyout_s;
    logic [NUM_SLV-1:0]   hresp_s;
    logic [32*NUM_SLV-1:0] hrdata_s;
    logic                 hready;
    logic                 hresp;
    logic [31:0]          hrdata;

    modport slave (
        input  haddr, htrans, hwrite, hsel_vec, defslv_hsel,
        input  hreadyout_s, hresp_s, hrdata_s,
        output hready, hresp, hrdata
    );

    modport master (
        output haddr, htrans, hwrite, hsel_vec, defslv_hsel,
        output hreadyout_s, hresp_s, hrdata_s,
        input  hready, hresp, hrdata
    );
endinterface

// File: rtl/cmsdk_mcu_ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// cmsdk_mcu_ahb_slave_mux
//   Data-phase AHB response multiplexer with a built-in default slave and a
//   first-error logger. The decoder's selects are registered in the address
//   phase; in the data phase the selected slave's hreadyout/hresp/hrdata are
//   routed back to the CPU. Unmapped accesses (no select, or an explicit
//   default-slave select) get a two-cycle AHB ERROR response.
//
//   Ports:
//     HCLK, HRESETn - clock, synchronous active-low reset
//     bus           - AHB request / per-slave response / muxed response bundle
//     err_clr       - single-cycle pulse clearing the error log
//     err_valid     - sticky flag: an ERROR response has completed
//     err_addr      - address of the first logged ERROR
//     err_write     - hwrite of the first logged ERROR
//     err_count     - saturating count of completed ERROR responses
// ----------------------------------------------------------------------------
module cmsdk_mcu_ahb_slave_mux #(
    parameter int NUM_SLV = 8
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    cmsdk_mcu_ahb_slave_mux_if.slave      bus,
    input  logic                          err_clr,
    output logic                          err_valid,
    output logic [31:0]                   err_addr,
    output logic                          err_write,
    output logic [7:0]                    err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } dflt_state_t;

    localparam logic [NUM_SLV:0] DSEL_DEFAULT = {1'b1, {NUM_SLV{1'b0}}};

    dflt_state_t          state_q, state_d;
    logic [NUM_SLV:0]     dsel_q, dsel_d;
    logic [31:0]          dp_addr_q;
    logic                 dp_write_q;

    logic                 default_sel_a;
    logic [NUM_SLV-1:0]   lowest_sel;
    logic                 hready_mux;
    logic                 hresp_mux;
    logic [31:0]          hrdata_mux;
    logic                 err_event;

    // ------------------------------------------------------------------
    // Address-phase select decode
    // ------------------------------------------------------------------
    // Explicit default select wins over any slave select; an empty vector
    // also lands on the default slave.
    assign default_sel_a = bus.defslv_hsel | ~(|bus.hsel_vec);

    // Two's-complement trick isolates the lowest set bit: lowest index wins.
    assign lowest_sel = bus.hsel_vec & (~bus.hsel_vec + {{(NUM_SLV-1){1'b0}}, 1'b1});

    always_comb begin
        // NOTE: every signal written in a combinational block gets a value
        // on entry, so no path through the block can infer a latch.
        dsel_d = DSEL_DEFAULT;
        if (!default_sel_a) begin
            dsel_d = {1'b0, lowest_sel};
        end
    end

    // ------------------------------------------------------------------
    // Default-slave FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ERR2: begin
                // Only an active transfer (NONSEQ/SEQ) to the default slave
                // earns an ERROR; IDLE/BUSY get a zero-wait OKAY.
                if (hready_mux && bus.htrans[1] && default_sel_a) begin
                    state_d = ERR1;
                end else begin
                    state_d = IDLE;
                end
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Data-phase response mux (combinational from the registered select)
    // ------------------------------------------------------------------
    always_comb begin
        hready_mux = 1'b1;
        hresp_mux  = 1'b0;
        hrdata_mux = 32'h0;
        if (dsel_q[NUM_SLV]) begin
            hready_mux = (state_q != ERR1);
            hresp_mux  = (state_q != IDLE);
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dsel_q[i]) begin
                hready_mux = bus.hreadyout_s[i];
                hresp_mux  = bus.hresp_s[i];
                hrdata_mux = bus.hrdata_s[32*i +: 32];
            end
        end
    end

    assign bus.hready = hready_mux;
    assign bus.hresp  = hresp_mux;
    assign bus.hrdata = hrdata_mux;

    // The second cycle of any ERROR response is the one that completes it.
    assign err_event = hready_mux & hresp_mux;

    // ------------------------------------------------------------------
    // State, select and data-phase registers
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!HRESETn) begin
            state_q    <= IDLE;
            dsel_q     <= DSEL_DEFAULT;
            dp_addr_q  <= 32'h0;
            dp_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // A stalled data phase holds the select and captured request.
            if (hready_mux) begin
                dsel_q     <= dsel_d;
                dp_addr_q  <= bus.haddr;
                dp_write_q <= bus.hwrite;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error log
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_valid <= 1'b0;
            err_addr  <= 32'h0;
            err_write <= 1'b0;
            err_count <= 8'h00;
        end else if (err_clr && err_event) begin
            // Clear and a new error on the same edge: start a fresh log.
            err_valid <= 1'b1;
            err_addr  <= dp_addr_q;
            err_write <= dp_write_q;
            err_count <= 8'h01;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= 32'h0;
            err_write <= 1'b0;
            err_count <= 8'h00;
        end else if (err_event) begin
            if (!err_valid) begin
                err_valid <= 1'b1;
                err_addr  <= dp_addr_q;
                err_write <= dp_write_q;
            end
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_cmsdk_mcu_ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// tb_cmsdk_mcu_ahb_slave_mux
//   Directed bench for the AHB data-phase response mux. Inputs change 1 ns
//   after a rising edge; outputs are checked at that point.
// ----------------------------------------------------------------------------
module tb_cmsdk_mcu_ahb_slave_mux;

    localparam int NUM_SLV = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_write;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    cmsdk_mcu_ahb_slave_mux_if #(.NUM_SLV(NUM_SLV)) bus ();

    cmsdk_mcu_ahb_slave_mux #(.NUM_SLV(NUM_SLV)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus.slave),
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_write (err_write),
        .err_count (err_count)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_idle();
        bus.haddr       = 32'h0;
        bus.htrans      = 2'b00;
        bus.hwrite      = 1'b0;
        bus.hsel_vec    = '0;
        bus.defslv_hsel = 1'b0;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [1:0] trans, input logic wr,
                             input logic [7:0] sel, input logic dflt);
        bus.haddr       = addr;
        bus.htrans      = trans;
        bus.hwrite      = wr;
        bus.hsel_vec    = sel;
        bus.defslv_hsel = dflt;
    endtask

    // One complete unmapped NONSEQ: address phase, ERR1, ERR2, completion edge.
    task automatic unmapped_error(input logic [31:0] addr);
        drive_req(addr, 2'b10, 1'b0, 8'h00, 1'b0);
        step();
        drive_idle();
        step();
        step();
    endtask

    initial begin
        HRESETn         = 1'b0;
        err_clr         = 1'b0;
        drive_idle();
        bus.hreadyout_s = '1;
        bus.hresp_s     = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            bus.hrdata_s[32*i +: 32] = 32'h1000_0000 + 32'(i);
        end

        // 1. Reset and idle bus
        step();
        step();
        HRESETn = 1'b1;
        step();
        check("rst_hready", 32'(bus.hready), 32'd1);
        check("rst_hresp",  32'(bus.hresp),  32'd0);
        check("rst_hrdata", bus.hrdata,      32'h0);
        check("rst_count",  32'(err_count),  32'd0);
        check("rst_valid",  32'(err_valid),  32'd0);

        // 2. SRAM read with two wait states
        bus.hreadyout_s[2] = 1'b0;
        bus.hrdata_s[32*2 +: 32] = 32'hCAFE_F00D;
        drive_req(32'h2000_0010, 2'b10, 1'b0, 8'h04, 1'b0);
        step();
        drive_idle();
        check("sram_wait1", 32'(bus.hready), 32'd0);
        step();
        check("sram_wait2", 32'(bus.hready), 32'd0);
        bus.hreadyout_s[2] = 1'b1;
        #1;
        check("sram_ready", 32'(bus.hready), 32'd1);
        check("sram_rdata", bus.hrdata,      32'hCAFE_F00D);
        check("sram_hresp", 32'(bus.hresp),  32'd0);
        step();

        // 3. Unmapped write
        drive_req(32'h3000_0000, 2'b10, 1'b1, 8'h00, 1'b0);
        step();
        drive_idle();
        check("err1_hready", 32'(bus.hready), 32'd0);
        check("err1_hresp",  32'(bus.hresp),  32'd1);
        step();
        check("err2_hready", 32'(bus.hready), 32'd1);
        check("err2_hresp",  32'(bus.hresp),  32'd1);
        check("err2_valid",  32'(err_valid),  32'd0);
        step();
        check("t3_hresp",  32'(bus.hresp), 32'd0);
        check("t3_valid",  32'(err_valid), 32'd1);
        check("t3_addr",   err_addr,       32'h3000_0000);
        check("t3_write",  32'(err_write), 32'd1);
        check("t3_count",  32'(err_count), 32'd1);

        // Plain clear
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_valid", 32'(err_valid), 32'd0);
        check("clr_count", 32'(err_count), 32'd0);
        check("clr_addr",  err_addr,       32'h0);

        // 4. Back-to-back unmapped NONSEQs
        drive_req(32'h3000_0000, 2'b10, 1'b0, 8'h00, 1'b0);
        step();
        drive_idle();
        check("b2b_a_err1", {30'h0, bus.hready, bus.hresp}, 32'd1);
        step();
        check("b2b_a_err2", {30'h0, bus.hready, bus.hresp}, 32'd3);
        drive_req(32'h5000_0000, 2'b10, 1'b0, 8'h00, 1'b0);
        step();
        drive_idle();
        check("b2b_b_err1", {30'h0, bus.hready, bus.hresp}, 32'd1);
        check("b2b_cnt1",   32'(err_count), 32'd1);
        step();
        check("b2b_b_err2", {30'h0, bus.hready, bus.hresp}, 32'd3);
        step();
        check("b2b_idle",  {30'h0, bus.hready, bus.hresp}, 32'd2);
        check("b2b_addr",  err_addr,       32'h3000_0000);
        check("b2b_count", 32'(err_count), 32'd2);
        check("b2b_write", 32'(err_write), 32'd0);

        // 5. Clear coinciding with an error completion, then saturation
        drive_req(32'h6000_0004, 2'b10, 1'b0, 8'h00, 1'b0);
        step();
        drive_idle();
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clrev_valid", 32'(err_valid), 32'd1);
        check("clrev_addr",  err_addr,       32'h6000_0004);
        check("clrev_count", 32'(err_count), 32'd1);
        for (int n = 0; n < 253; n++) begin
            unmapped_error(32'h7000_0000 + 32'(n));
        end
        check("sat_254", 32'(err_count), 32'hFE);
        unmapped_error(32'h7100_0000);
        check("sat_255", 32'(err_count), 32'hFF);
        unmapped_error(32'h7200_0000);
        unmapped_error(32'h7300_0000);
        check("sat_hold", 32'(err_count), 32'hFF);
        check("sat_addr", err_addr,       32'h6000_0004);

        // 6. Reset in the middle of ERR1
        drive_req(32'h8000_0000, 2'b10, 1'b1, 8'h00, 1'b0);
        step();
        drive_idle();
        check("mid_err1", {30'h0, bus.hready, bus.hresp}, 32'd1);
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
        check("mrst_bus",   {30'h0, bus.hready, bus.hresp}, 32'd2);
        check("mrst_state", 32'(dut.state_q), 32'd0);
        check("mrst_valid", 32'(err_valid), 32'd0);
        check("mrst_addr",  err_addr,       32'h0);
        check("mrst_write", 32'(err_write), 32'd0);
        check("mrst_count", 32'(err_count), 32'd0);
        // IDLE then BUSY transfers to the default slave: zero-wait OKAY
        drive_req(32'h9000_0000, 2'b00, 1'b0, 8'h00, 1'b0);
        step();
        drive_req(32'h9000_0004, 2'b01, 1'b0, 8'h00, 1'b0);
        check("idle_okay", {30'h0, bus.hready, bus.hresp}, 32'd2);
        check("idle_rdat", bus.hrdata, 32'h0);
        step();
        drive_idle();
        check("busy_okay", {30'h0, bus.hready, bus.hresp}, 32'd2);
        step();
        check("okay_count", 32'(err_count), 32'd0);

        // Lowest index wins among multiple selects
        drive_req(32'h4001_0000, 2'b10, 1'b0, 8'h30, 1'b0);
        step();
        drive_idle();
        check("prio_rdata", bus.hrdata, 32'h1000_0004);
        step();

        // defslv_hsel overrides a slave select
        drive_req(32'hA000_0000, 2'b10, 1'b1, 8'h02, 1'b1);
        step();
        drive_idle();
        check("ovr_err1", {30'h0, bus.hready, bus.hresp}, 32'd1);
        step();
        step();
        check("ovr_addr",  err_addr,       32'hA000_0000);
        check("ovr_count", 32'(err_count), 32'd1);

        // ERROR response from a real slave counts as an event too
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        drive_req(32'h4000_0000, 2'b10, 1'b1, 8'h08, 1'b0);
        step();
        drive_idle();
        bus.hresp_s[3] = 1'b1;
        #1;
        check("slv_err", {30'h0, bus.hready, bus.hresp}, 32'd3);
        step();
        bus.hresp_s[3] = 1'b0;
        check("slv_valid", 32'(err_valid), 32'd1);
        check("slv_addr",  err_addr,       32'h4000_0000);
        check("slv_write", 32'(err_write), 32'd1);
        check("slv_count", 32'(err_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
